psum_requant_drain: RTL and testbench
=====================================

PSUM_REQUANT_DRAIN -- requirements
Module: psum_requant_drain

Interface
REQ-001 SHALL have parameter PSUM_BW, default 32, width of one stored partial sum.
REQ-002 SHALL have parameter ADDR_PSUM, default 12, psum buffer address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to drain one psum tile.
REQ-006 SHALL have port num_words  input  ADDR_PSUM+1  psum entries to drain, 0..4096.
REQ-007 SHALL have ports bias (signed 32), scale (unsigned 16), shift (5) as inputs: requant parameters.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at drain completion.
REQ-010 SHALL have ports psum_rd_en (output 1), psum_rd_addr (output ADDR_PSUM), psum_rd_data (input signed PSUM_BW): psum buffer read port, data valid exactly 1 cycle after rd_en.
REQ-011 SHALL have ports m_data (output 32), m_valid (output 1), m_ready (input 1), m_last (output 1): packed int8 output stream.

Function
REQ-012 SHALL implement FSM IDLE -> RUN (start, num_words>0) -> DRAIN (last read issued) -> IDLE (last word accepted, done pulse); start with num_words=0 pulses done next cycle, no m_valid.
REQ-013 SHALL latch num_words, bias, scale, shift at accepted start; start while busy ignored.
REQ-014 SHALL read addresses 0..num_words-1 in increasing order, one per cycle unless throttled.
REQ-015 SHALL compute per element: s = psum + bias (33-bit signed); p = s * scale (50-bit signed); r = shift==0 ? p : (p + 2^(shift-1)) >>> shift; q = clamp(r, -128, 127).
REQ-016 SHALL pipeline as read, add, multiply, round/clamp (one register each).
REQ-017 SHALL pack four q bytes per word, element 4k in m_data[7:0], 4k+3 in [31:24]; final partial word zero-padded.
REQ-018 SHALL assert m_last with the final word only.
REQ-019 SHALL hold m_data/m_valid/m_last stable while m_valid && !m_ready; transfer on m_valid && m_ready.
REQ-020 SHALL buffer at most 16 quantized bytes (in-flight plus packed); psum_rd_en SHALL be low whenever one more read could exceed this; no element dropped or duplicated under any m_ready pattern.
REQ-021 SHALL, with m_ready held 1 and num_words>=4, first assert m_valid 9 cycles after the start cycle and sustain one word per 4 cycles.
REQ-022 SHALL pulse done the cycle after the final word transfers; busy falls same cycle.

Reset
REQ-023 SHALL on reset assertion immediately clear busy, done, psum_rd_en, psum_rd_addr, m_data, m_valid, m_last to 0, FSM to IDLE, all buffers empty.
REQ-024 SHALL accept a new start the first cycle after reset deasserts; reset mid-drain discards partial tile.

Configuration
REQ-025 SHALL compile port relu_en (input 1) only when PSUM_DRAIN_RELU_EN is defined; relu_en=1 then clamps q to [0,127].
REQ-026 SHALL, without PSUM_DRAIN_RELU_EN, have no relu_en port and clamp to [-128,127].

Verification
REQ-027 SHALL cover: num_words=4, psum 10,20,-30,300, bias 0, scale 1, shift 0, m_ready=1 -> one word 0x7FE2140A, m_last=1, done next cycle.
REQ-028 SHALL cover rounding: psum 5, bias 1, scale 3, shift 2 -> q=5; psum -7, bias 0, scale 1, shift 1 -> q=-3 (0xFD).
REQ-029 SHALL cover partial: num_words=6, psum 1..6 -> words 0x04030201 then 0x00000605 with m_last.
REQ-030 SHALL cover backpressure: num_words=64, m_ready high 1 cycle in 3 -> 16 words in order, no loss, buffer never exceeds 16 bytes.
REQ-031 SHALL cover reset during 5th word of 16 -> outputs 0 immediately; following start drains from address 0 correctly.
REQ-032 SHALL cover, with PSUM_DRAIN_RELU_EN, relu_en=1, psum -50, scale 1, shift 0 -> byte 0x00.

Source files
------------

// File: rtl/psum_requant_drain.sv
// Drains a psum tile, requantizes each entry to int8 and streams four packed bytes per word.
// Optional build macro PSUM_DRAIN_RELU_EN adds the relu_en port (clamp to [0,127]).
module psum_requant_drain #(
    parameter int PSUM_BW   = 32,
    parameter int ADDR_PSUM = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_PSUM:0]          num_words,
    input  logic signed [31:0]          bias,
    input  logic [15:0]                 scale,
    input  logic [4:0]                  shift,
`ifdef PSUM_DRAIN_RELU_EN
    input  logic                        relu_en,
`endif
    output logic                        busy,
    output logic                        done,
    output logic                        psum_rd_en,
    output logic [ADDR_PSUM-1:0]        psum_rd_addr,
    input  logic signed [PSUM_BW-1:0]   psum_rd_data,
    output logic [31:0]                 m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    logic [ADDR_PSUM:0]   n_l, rd_cnt, rd_cnt_next, out_left;
    logic signed [31:0]   bias_l;
    logic [15:0]          scale_l;
    logic [4:0]           shift_l;
    logic                 relu_l;
    logic [4:0]           cred, cred_next, fifo_cnt;
    logic [2:0]           need, m_bytes;
    logic                 load, xfer;
    logic                 vld_p0, vld_p1, vld_p2;
    logic signed [32:0]   s_p1;
    logic signed [49:0]   p_p2;
    logic [7:0]           fifo_mem [16];
    logic [3:0]           wr_ptr, rd_ptr;
    logic [31:0]          pack_word;
    logic [7:0]           q_byte;

    function automatic logic signed [50:0] round_shift(input logic signed [49:0] p,
                                                       input logic [4:0] sh);
        logic signed [50:0] x;
        x = 51'(p);
        if (sh != 5'd0)
            x = (x + (51'sd1 <<< (sh - 5'd1))) >>> sh;
        return x;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [50:0] r, input logic relu);
        logic signed [50:0] lo;
        lo = relu ? 51'sd0 : -51'sd128;
        if (r > 51'sd127)
            return 8'h7f;
        else if (r < lo)
            return lo[7:0];
        else
            return r[7:0];
    endfunction

    // cred counts every byte issued as a read and not yet handed off on m_data
    always_comb begin
        xfer        = m_valid && m_ready;
        cred_next   = cred + {4'b0, psum_rd_en} - (xfer ? {2'b0, m_bytes} : 5'd0);
        rd_cnt_next = rd_cnt + {{ADDR_PSUM{1'b0}}, psum_rd_en};
        need        = (|out_left[ADDR_PSUM:2]) ? 3'd4 : {1'b0, out_left[1:0]};
        load        = (out_left != '0) && (!m_valid || m_ready) && (fifo_cnt >= {2'b0, need});
        q_byte      = sat8(round_shift(p_p2, shift_l), relu_l);
        pack_word   = '0;
        for (int i = 0; i < 4; i++)
            pack_word[8*i +: 8] = (i < int'(need)) ? fifo_mem[rd_ptr + 4'(i)] : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            psum_rd_en   <= 1'b0;
            psum_rd_addr <= '0;
            rd_cnt       <= '0;
            n_l          <= '0;
            out_left     <= '0;
            cred         <= '0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_bytes      <= '0;
        end else begin
            done   <= 1'b0;
            cred   <= cred_next;
            vld_p0 <= psum_rd_en;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;

            if (vld_p2)
                wr_ptr <= wr_ptr + 4'd1;
            if (load)
                rd_ptr <= rd_ptr + 4'(need);
            fifo_cnt <= fifo_cnt + {4'b0, vld_p2} - (load ? {2'b0, need} : 5'd0);

            if (load) begin
                m_valid  <= 1'b1;
                m_data   <= pack_word;
                m_last   <= (out_left == (ADDR_PSUM+1)'(need));
                m_bytes  <= need;
                out_left <= out_left - (ADDR_PSUM+1)'(need);
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    psum_rd_en <= 1'b0;
                    if (start) begin
                        if (num_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            state        <= RUN;
                            busy         <= 1'b1;
                            n_l          <= num_words;
                            out_left     <= num_words;
                            rd_cnt       <= '0;
                            psum_rd_addr <= '0;
                            psum_rd_en   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rd_cnt       <= rd_cnt_next;
                    psum_rd_addr <= rd_cnt_next[ADDR_PSUM-1:0];
                    if (rd_cnt_next == n_l) begin
                        psum_rd_en <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        psum_rd_en <= (cred_next < 5'd16);
                    end
                end
                DRAIN: begin
                    if (xfer && m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            bias_l  <= bias;
            scale_l <= scale;
            shift_l <= shift;
`ifdef PSUM_DRAIN_RELU_EN
            relu_l  <= relu_en;
`endif
        end
        // add stage: psum_rd_data is valid while vld_p0
        s_p1 <= 33'(psum_rd_data) + 33'(bias_l);
        // multiply stage
        p_p2 <= 50'(s_p1) * 50'($signed({1'b0, scale_l}));
        // round/clamp stage lands directly in the byte buffer
        if (vld_p2)
            fifo_mem[wr_ptr] <= q_byte;
    end

`ifndef PSUM_DRAIN_RELU_EN
    assign relu_l = 1'b0;
`endif

endmodule

// File: tb/tb_psum_requant_drain.sv
// Scoreboard bench for psum_requant_drain: expected words queued at start, popped on transfer.
module tb_psum_requant_drain;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [12:0]        num_words = '0;
    logic signed [31:0] bias = '0;
    logic [15:0]        scale = '0;
    logic [4:0]         shift = '0;
`ifdef PSUM_DRAIN_RELU_EN
    logic               relu_en = 1'b0;
`endif
    logic               busy, done, psum_rd_en, m_valid, m_last;
    logic [11:0]        psum_rd_addr;
    logic signed [31:0] psum_rd_data;
    logic [31:0]        m_data;
    logic               m_ready = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_mode = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          nb;
    } exp_t;
    exp_t sbq[$];

    logic signed [31:0] mem [0:4095];

    int exp_addr = 0, inflight = 0, nxfer = 0;
    int first_valid_cyc = -1, done_cyc = -1, last_xfer_cyc = -1, start_cyc = 0;
    logic busy_at_done = 1'b0;
    bit hold_pend = 0;
    logic [31:0] hold_d = '0;
    logic hold_l = 1'b0;
    logic [31:0] last_word = '0;
    int xfer_cyc [0:63];

    psum_requant_drain #(.PSUM_BW(32), .ADDR_PSUM(12)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .bias(bias), .scale(scale), .shift(shift),
`ifdef PSUM_DRAIN_RELU_EN
        .relu_en(relu_en),
`endif
        .busy(busy), .done(done), .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr),
        .psum_rd_data(psum_rd_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 3 == 0);
            default: m_ready = ($urandom_range(0, 4) == 0);
        endcase
    end

    always @(posedge clk)
        if (psum_rd_en) psum_rd_data <= mem[psum_rd_addr];

    always @(negedge clk) begin
        if (!reset) begin
            if (psum_rd_en) begin
                total++;
                if (psum_rd_addr !== 12'(exp_addr)) begin
                    bad++;
                    $display("FAIL rd_addr got=%0d want=%0d", psum_rd_addr, exp_addr);
                end
                exp_addr++;
                inflight++;
            end
            total++;
            if (inflight > 16) begin
                bad++;
                $display("FAIL inflight got=%0d want<=16", inflight);
            end
            if (hold_pend) begin
                total++;
                if ({m_valid, m_data, m_last} !== {1'b1, hold_d, hold_l}) begin
                    bad++;
                    $display("FAIL hold got=%b/%h/%b want=1/%h/%b", m_valid, m_data, m_last, hold_d, hold_l);
                end
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word got=%h want=none", m_data);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if ({m_data, m_last} !== {e.d, e.l}) begin
                        bad++;
                        $display("FAIL word got=%h last=%b want=%h last=%b", m_data, m_last, e.d, e.l);
                    end
                    inflight -= e.nb;
                end
                last_word = m_data;
                if (nxfer < 64) xfer_cyc[nxfer] = cyc;
                nxfer++;
                if (m_last) last_xfer_cyc = cyc;
            end
            hold_pend = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            if (done && done_cyc < 0) begin
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
    end

    function automatic logic [7:0] model_q(longint ps, longint b, longint sc, int sh, bit rl);
        longint r;
        longint lo;
        r = (ps + b) * sc;
        if (sh != 0) r = (r + (longint'(1) <<< (sh - 1))) >>> sh;
        lo = rl ? 0 : -128;
        if (r > 127) r = 127;
        if (r < lo) r = lo;
        return 8'(r);
    endfunction

    task automatic kick(int n, int b, int sc, int sh, bit rl);
        exp_t e;
        for (int k = 0; k < n; k += 4) begin
            e.d = '0;
            e.nb = 0;
            for (int j = 0; j < 4; j++)
                if (k + j < n) begin
                    e.d[8*j +: 8] = model_q(mem[k+j], b, sc, sh, rl);
                    e.nb++;
                end
            e.l = (k + 4 >= n);
            sbq.push_back(e);
        end
        first_valid_cyc = -1; done_cyc = -1; last_xfer_cyc = -1;
        nxfer = 0; exp_addr = 0; start_cyc = cyc;
        num_words = 13'(n); bias = b; scale = 16'(sc); shift = 5'(sh);
`ifdef PSUM_DRAIN_RELU_EN
        relu_en = rl;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int budget, output bit ok);
        ok = 0;
        repeat (budget) begin
            @(negedge clk);
            if (done_cyc >= 0) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, psum_rd_en, psum_rd_addr, m_data, m_valid, m_last} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b%b%b %h %h %b%b want=all zero", busy, done, psum_rd_en, psum_rd_addr, m_data, m_valid, m_last);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        mem[0] = 10; mem[1] = 20; mem[2] = -30; mem[3] = 300;
        kick(4, 0, 1, 0, 0);
        wait_done(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=nodone want=done"); end
        total++; if (last_word !== 32'h7FE2140A) begin bad++; $display("FAIL basic_word got=%h want=7fe2140a", last_word); end
        total++; if (nxfer != 1) begin bad++; $display("FAIL basic_count got=%0d want=1", nxfer); end
        total++; if (first_valid_cyc != start_cyc + 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", first_valid_cyc - start_cyc); end
        total++; if (done_cyc != last_xfer_cyc + 1) begin bad++; $display("FAIL basic_done got=%0d want=%0d", done_cyc, last_xfer_cyc + 1); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", busy_at_done); end
    endtask

    task automatic test_rounding();
        bit ok;
        mem[0] = 5;
        kick(1, 1, 3, 2, 0);
        wait_done(200, ok);
        total++; if (!ok || last_word !== 32'h00000005) begin bad++; $display("FAIL round_pos got=%h want=00000005", last_word); end
        mem[0] = -7;
        kick(1, 0, 1, 1, 0);
        wait_done(200, ok);
        total++; if (!ok || last_word !== 32'h000000FD) begin bad++; $display("FAIL round_neg got=%h want=000000fd", last_word); end
    endtask

    task automatic test_partial();
        bit ok;
        for (int i = 0; i < 6; i++) mem[i] = i + 1;
        kick(6, 0, 1, 0, 0);
        wait_done(200, ok);
        total++; if (!ok || nxfer != 2) begin bad++; $display("FAIL partial_count got=%0d want=2", nxfer); end
        total++; if (last_word !== 32'h00000605) begin bad++; $display("FAIL partial_last got=%h want=00000605", last_word); end
    endtask

    task automatic test_zero();
        kick(0, 0, 1, 0, 0);
        repeat (4) @(negedge clk);
        total++; if (done_cyc != start_cyc + 1) begin bad++; $display("FAIL zero_done got=%0d want=%0d", done_cyc, start_cyc + 1); end
        total++; if (first_valid_cyc != -1 || busy !== 1'b0) begin bad++; $display("FAIL zero_quiet got=valid@%0d busy=%b want=none/0", first_valid_cyc, busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i < 16; i++) mem[i] = $urandom_range(0, 400) - 200;
        kick(16, $urandom_range(0, 40) - 20, $urandom_range(1, 5), $urandom_range(0, 4), 0);
        wait_done(300, ok);
        total++; if (!ok || nxfer != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", nxfer); end
        total++; if (first_valid_cyc != start_cyc + 9) begin bad++; $display("FAIL b2b_latency got=%0d want=9", first_valid_cyc - start_cyc); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (xfer_cyc[i+1] - xfer_cyc[i] != 4) begin bad++; $display("FAIL b2b_rate got=%0d want=4", xfer_cyc[i+1] - xfer_cyc[i]); end
        end
        for (int i = 0; i < 13; i++) mem[i] = $urandom;
        kick(13, $urandom, $urandom_range(0, 65535), $urandom_range(0, 31), 0);
        wait_done(300, ok);
        total++; if (!ok || sbq.size() != 0 || nxfer != 4) begin bad++; $display("FAIL b2b_second got=%0d left=%0d want=4 left=0", nxfer, sbq.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        ready_mode = 1;
        for (int i = 0; i < 64; i++) mem[i] = $urandom_range(0, 2000) - 1000;
        kick(64, 7, 3, 3, 0);
        repeat (20) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b want=1", busy); end
        num_words = 13'd5; bias = 32'sd99; scale = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, ok);
        total++; if (!ok || nxfer != 16 || sbq.size() != 0) begin bad++; $display("FAIL bp_third got=%0d left=%0d want=16 left=0", nxfer, sbq.size()); end
        ready_mode = 2;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        kick(64, $urandom, $urandom_range(0, 65535), $urandom_range(10, 31), 0);
        wait_done(4000, ok);
        total++; if (!ok || nxfer != 16 || sbq.size() != 0) begin bad++; $display("FAIL bp_random got=%0d left=%0d want=16 left=0", nxfer, sbq.size()); end
        ready_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        for (int i = 0; i < 64; i++) mem[i] = i;
        kick(64, 0, 1, 0, 0);
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (nxfer >= 4) begin seen = 1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_reach got=%0d want=4", nxfer); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({busy, done, psum_rd_en, psum_rd_addr, m_data, m_valid, m_last} !== '0) begin
            bad++;
            $display("FAIL rstmid_clear got=%b%b%b %h %h %b%b want=all zero", busy, done, psum_rd_en, psum_rd_addr, m_data, m_valid, m_last);
        end
        sbq.delete();
        inflight = 0;
        hold_pend = 0;
        for (int i = 0; i < 8; i++) mem[i] = 40 - 11 * i;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        kick(8, 2, 2, 1, 0);
        wait_done(300, ok);
        total++; if (!ok || nxfer != 2 || sbq.size() != 0) begin bad++; $display("FAIL rstmid_after got=%0d left=%0d want=2 left=0", nxfer, sbq.size()); end
    endtask

`ifdef PSUM_DRAIN_RELU_EN
    task automatic test_relu();
        bit ok;
        mem[0] = -50; mem[1] = 5; mem[2] = -128; mem[3] = 200;
        kick(4, 0, 1, 0, 1);
        wait_done(200, ok);
        total++; if (!ok || last_word !== 32'h7F000500) begin bad++; $display("FAIL relu_word got=%h want=7f000500", last_word); end
        relu_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_partial();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef PSUM_DRAIN_RELU_EN
        test_relu();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
